// File: rtl/exp_stream_wrapper.sv
// Streams 32-bit operand words into the 512-bit modexp core and streams its result back out.
// Operands x, m, e arrive as 3*NWORDS little-endian words; the result leaves as NWORDS words.
module exp_stream_wrapper #(
  parameter  int WORD_W = 32,
  parameter  int OP_W   = 512,
  localparam int NWORDS = OP_W / WORD_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              exp_start,
  output logic [OP_W-1:0]   exp_x,
  output logic [OP_W-1:0]   exp_m,
  output logic [OP_W-1:0]   exp_e,
  input  logic              exp_done,
  input  logic [OP_W-1:0]   exp_result,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(3 * NWORDS);
  localparam logic [CNT_W-1:0] CNT_IN_LAST  = CNT_W'(3 * NWORDS - 1);
  localparam logic [CNT_W-1:0] CNT_OUT_LAST = CNT_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_START  = 2'd1,
    S_WAIT   = 2'd2,
    S_UNLOAD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   x_q, x_d, m_q, m_d, e_q, e_d, res_q, res_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              exp_start_q, exp_start_d;
  logic              busy_q, busy_d;
  logic              in_fire, out_fire;
  logic [WORD_W-1:0] out_word;

  // Handshakes: a word moves on a rising edge where valid & ready are both high.
  // Neither ready nor valid here depends combinationally on the other side.
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    m_d     = m_q;
    e_d     = e_q;
    res_d   = res_q;
    case (state_q)
      S_LOAD: begin
        if (in_fire) begin
          // Counter 0..NWORDS-1 selects x, then m, then e.
          for (int k = 0; k < NWORDS; k++) begin
            if (int'(cnt_q) == k)              x_d[k*WORD_W +: WORD_W] = in_data;
            if (int'(cnt_q) == k + NWORDS)     m_d[k*WORD_W +: WORD_W] = in_data;
            if (int'(cnt_q) == k + 2 * NWORDS) e_d[k*WORD_W +: WORD_W] = in_data;
          end
          if (cnt_q == CNT_IN_LAST) begin
            cnt_d   = '0;
            state_d = S_START;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (exp_done) begin
          res_d   = exp_result;
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        if (out_fire) begin
          if (cnt_q == CNT_OUT_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
    // Control outputs are registered copies of the next-state decode.
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_UNLOAD);
    exp_start_d = (state_d == S_START);
    busy_d      = (state_d != S_LOAD);
  end

  always_comb begin
    out_word = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (int'(cnt_q) == k) out_word = res_q[k*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      x_q         <= '0;
      m_q         <= '0;
      e_q         <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      exp_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      m_q         <= m_d;
      e_q         <= e_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      exp_start_q <= exp_start_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? out_word : '0;
  assign out_last  = out_valid_q && (cnt_q == CNT_OUT_LAST);
  assign busy      = busy_q;
  assign exp_start = exp_start_q;
  assign exp_x     = x_q;
  assign exp_m     = m_q;
  assign exp_e     = e_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_exp_stream_wrapper.sv
// Bench for exp_stream_wrapper: behavioural modexp core, word driver, output scoreboard.
module tb_exp_stream_wrapper;

  localparam int OP_W   = 512;
  localparam int NWORDS = 16;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         exp_start;
  logic [511:0] exp_x, exp_m, exp_e;
  logic         exp_done;
  logic [511:0] exp_result;
  logic [1:0]   state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0]   exp_q[$];
  logic [1535:0] op_q[$];
  int            pops = 0, starts = 0, lasts = 0;
  int            stall_at = -1, stall_left = 0;
  logic [32:0]   held = '0;
  logic          expect_rdy = 1'b0;
  int            core_cnt;

  exp_stream_wrapper dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .exp_start(exp_start),
    .exp_x(exp_x), .exp_m(exp_m), .exp_e(exp_e),
    .exp_done(exp_done), .exp_result(exp_result), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [511:0] modexp(input logic [511:0] b, input logic [511:0] m,
                                          input logic [511:0] e);
    logic [1023:0] r, bb, mm;
    mm = {512'd0, m};
    bb = {512'd0, b} % mm;
    r  = '0;
    if (m != 512'd1) r[0] = 1'b1;
    for (int i = OP_W - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * bb) % mm;
    end
    return r[511:0];
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int k = 0; k < NWORDS; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- core model: done 20 cycles after start, held until next start ----------------
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_done   <= 1'b0;
      exp_result <= '0;
      core_cnt   <= 0;
    end else if (exp_start) begin
      exp_done   <= 1'b0;
      exp_result <= modexp(exp_x, exp_m, exp_e);
      core_cnt   <= 20;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) exp_done <= 1'b1;
    end
  end

  // ---------------- monitor / scoreboard (owns out_ready) ----------------
  always @(negedge clk) begin : mon
    logic [1535:0] op;
    logic [32:0]   w;
    if (resetn) begin
      if (expect_rdy) begin
        check_val("rdy_after_last", in_ready, 1);
        check_val("idle_after_last", busy, 0);
        expect_rdy = 1'b0;
      end
      if (busy) check_val("rdy_while_busy", in_ready, 0);
      if (exp_start) begin
        starts++;
        if (op_q.size() == 0) check_val("start_unexpected", 1, 0);
        else begin
          op = op_q.pop_front();
          check_val("start_x", exp_x, op[511:0]);
          check_val("start_m", exp_m, op[1023:512]);
          check_val("start_e", exp_e, op[1535:1024]);
        end
      end
      if (out_valid) begin
        check_val("busy_in_unload", busy, 1);
        if (stall_left > 0) begin
          check_val("stall_hold", {out_last, out_data}, held);
          stall_left--;
          if (stall_left == 0) out_ready = 1'b1;
        end else if (pops == stall_at && out_ready) begin
          out_ready  = 1'b0;
          held       = {out_last, out_data};
          stall_left = 10;
        end
        if (out_ready) begin
          if (exp_q.size() == 0) check_val("out_unexpected", 1, 0);
          else begin
            w = exp_q.pop_front();
            check_val("out_word", {out_last, out_data}, w);
          end
          pops++;
          if (out_last) begin
            lasts++;
            expect_rdy = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d);
    int g;
    g        = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) check_val("in_ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Leaves in_valid high after the last word so a following job keeps pressing on in_ready.
  task automatic start_job(input logic [511:0] x, input logic [511:0] m, input logic [511:0] e,
                           input bit gaps, input bit use_model, input logic [511:0] fixed_res);
    logic [511:0] r, op;
    logic         lst;
    op_q.push_back({e, m, x});
    r = use_model ? modexp(x, m, e) : fixed_res;
    for (int k = 0; k < NWORDS; k++) begin
      lst = (k == NWORDS - 1);
      exp_q.push_back({lst, r[k*32 +: 32]});
    end
    for (int i = 0; i < 3 * NWORDS; i++) begin
      op = (i < NWORDS) ? x : (i < 2 * NWORDS) ? m : e;
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send_word(op[(i % NWORDS)*32 +: 32]);
    end
  endtask

  task automatic wait_idle();
    int g;
    g        = 0;
    in_valid = 1'b0;
    while (!(exp_q.size() == 0 && in_ready && !busy) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) check_val("idle_timeout", 0, 1);
  endtask

  task automatic do_reset_check();
    resetn   = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_exp_start", exp_start, 0);
    check_val("rst_exp_x", exp_x, 0);
    check_val("rst_exp_m", exp_m, 0);
    check_val("rst_exp_e", exp_e, 0);
    check_val("rst_state", state_dbg, 0);
    exp_q.delete();
    op_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("rdy_after_reset", in_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [511:0] xb, mb, eb, xr, mr, er, rr;
    int           s0, p0, l0, g;

    resetn = 1'b0;
    repeat (2) @(negedge clk);
    do_reset_check();

    // Small job: 5^3 mod 101 = 125 - 101 = 24
    s0 = starts; p0 = pops; l0 = lasts;
    start_job(512'd5, 512'h65, 512'd3, 1'b0, 1'b0, 512'h18);
    wait_idle();
    check_val("a_starts", starts - s0, 1);
    check_val("a_words", pops - p0, 16);
    check_val("a_lasts", lasts - l0, 1);

    // Wide job with gaps, immediately followed by a random job pressing on in_ready
    xb = '0; mb = '0;
    for (int k = 0; k < NWORDS - 1; k++) begin
      xb[k*32 +: 32] = 32'(32'h1f3d5b79 * (k + 1)) ^ 32'hc0ffee11;
      mb[k*32 +: 32] = 32'(32'h9e3779b9 * (k + 3)) ^ 32'h5a5a1234;
    end
    xb[511:480] = 32'h87b21d93;
    mb[511:480] = 32'hbdb2a4a4;
    mb[0]       = 1'b1;
    eb          = 512'haf;
    xr = rand512(); mr = rand512() | {1'b1, 511'd0} | 512'd1; er = rand512();
    s0 = starts; p0 = pops;
    start_job(xb, mb, eb, 1'b1, 1'b1, '0);
    start_job(xr, mr, er, 1'b1, 1'b1, '0);
    wait_idle();
    check_val("bc_starts", starts - s0, 2);
    check_val("bc_words", pops - p0, 32);

    // Output stall of 10 cycles at word 7
    xr = rand512(); mr = rand512() | {1'b1, 511'd0} | 512'd1; er = rand512();
    p0 = pops;
    stall_at = pops + 7;
    start_job(xr, mr, er, 1'b0, 1'b1, '0);
    wait_idle();
    check_val("d_words", pops - p0, 16);
    check_val("d_stall_done", stall_left, 0);

    // Reset while waiting for the core
    xr = rand512(); mr = rand512() | {1'b1, 511'd0} | 512'd1; er = rand512();
    start_job(xr, mr, er, 1'b0, 1'b1, '0);
    in_valid = 1'b0;
    g = 0;
    while (state_dbg != 2'd2 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_val("reached_wait", state_dbg, 2);
    #2;
    do_reset_check();

    // Reset while word 4 of the result is on the output
    xr = rand512(); mr = rand512() | {1'b1, 511'd0} | 512'd1; er = rand512();
    rr = modexp(xr, mr, er);
    p0 = pops;
    start_job(xr, mr, er, 1'b0, 1'b1, '0);
    in_valid = 1'b0;
    g = 0;
    while (pops != p0 + 4 && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    check_val("reached_word4", pops - p0, 4);
    @(posedge clk);
    #2;
    check_val("pre_rst_word4", out_data, rr[4*32 +: 32]);
    do_reset_check();

    // Full job after the aborted ones
    xr = rand512(); mr = rand512() | {1'b1, 511'd0} | 512'd1; er = rand512();
    s0 = starts; p0 = pops;
    start_job(xr, mr, er, 1'b1, 1'b1, '0);
    wait_idle();
    check_val("g_starts", starts - s0, 1);
    check_val("g_words", pops - p0, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exp_stream_wrapper.md
Name: exp_stream_wrapper

Overview:
- Bus-facing stage that sits directly in front of the `exp` modular-exponentiation core.
- Collects the 512-bit operands x, m and e as a stream of 32-bit words, drives the core's `in_x`/`in_m`/`in_e` and `start`, and waits for `done`.
- Captures `result` and streams it back out as 32-bit words.
- Decouples the narrow host/DMA interface from the 512-bit core datapath.

Parameters:
- WORD_W, 32, stream word width in bits.
- OP_W, 512, operand width; must be a multiple of WORD_W.
- NWORDS, OP_W/WORD_W (16), words per operand; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  wrapper accepts a word when in_valid & in_ready.
- in_data  in  WORD_W  operand word.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts a word when out_valid & out_ready.
- out_data  out  WORD_W  result word.
- out_last  out  1  high with the final (NWORDS-1) result word.
- busy  out  1  high in every state except LOAD.
- exp_start  out  1  to core `start`.
- exp_x, exp_m, exp_e  out  OP_W each  to core `in_x`, `in_m`, `in_e`.
- exp_done  in  1  from core `done`.
- exp_result  in  OP_W  from core `result`.

Behaviour:
- Reset (async, resetn=0), values forced immediately:
  - state=LOAD, word counter=0.
  - exp_x, exp_m, exp_e, result register = 0.
  - exp_start=0, in_ready=0 during reset and 1 after release, out_valid=0, out_last=0, out_data=0, busy=0.
- Reset mid-operation aborts everything. Partial operands and an in-flight result are discarded; the core is expected to share resetn.
- Word order: little-endian within each operand. Word k lands in bits [32k+31:32k].
- Operand order: 16 words of x, then 16 of m, then 16 of e. A 6-bit counter runs 0..47.
- LOAD:
  - in_ready=1. Each handshake writes in_data into the operand/word selected by the counter, then increments the counter.
  - The handshake at counter=47 writes e[511:480], clears the counter and moves to START the next cycle.
  - in_valid=0 does nothing; there is no timeout.
- START:
  - exp_start=1 for exactly one cycle, then WAIT.
  - exp_x/m/e stay stable from START until the next LOAD handshake overwrites them.
- WAIT:
  - exp_start=0, in_ready=0.
  - On the first cycle with exp_done=1, latch exp_result into the result register, then go to UNLOAD.
  - exp_done is ignored in every other state.
- UNLOAD:
  - out_valid=1, out_data = result word selected by the counter (word 0 first), out_last=1 when counter=15.
  - Each handshake advances the counter. out_valid=0 and out_ready do not interact combinationally.
  - The handshake with out_last=1 clears the counter and returns to LOAD; in_ready=1 on the following cycle.
  - out_ready=0 holds out_data and out_last stable (no drop, no repeat).
- Latency:
  - Last input handshake to exp_start high: 1 cycle.
  - exp_done to out_valid: 1 cycle.
  - Best-case output rate: 1 word/cycle.
- in_ready and out_valid are never high in the same cycle. Input arriving outside LOAD is back-pressured, not dropped.
- All outputs are registered, except that out_data/out_last may be a mux of registered state.

Test Plan:
- The bench uses a behavioural core model: result = x^e mod m, `done` high 20 cycles after `start`, `done` held until the next `start`.
- Load x=5, m=0x65, e=3 (upper words 0), out_ready=1 throughout:
  - exactly one exp_start pulse;
  - 16 output words, word0=0x18, words1..15=0, out_last only on word 15.
- Load the 512-bit vector x=0x87b21d93..., m=0xbdb2a4a4..., e=0xaf:
  - exp_x/exp_m/exp_e equal the full vectors at START;
  - streamed result equals the model value word for word.
- Toggle in_valid randomly during load, and drive in_valid=1 continuously while busy:
  - no words are lost;
  - in_ready=0 from START until the handshake after out_last;
  - the second job loads correctly.
- Hold out_ready=0 for 10 cycles at word 7, then release:
  - out_data stays at word 7 throughout the stall;
  - word 7 is delivered exactly once, followed by word 8.
- Assert resetn=0 during WAIT and again at UNLOAD word 4:
  - all outputs read back their reset values;
  - a following full job completes correctly, starting from x word 0.
